// File: rtl/input_pkg.sv
// input_pkg: shared definitions for the input front-end.
//   - channel index constants (CH_*)
//   - KEY_CODES_DEF: default scan-code table, channel i in bits [8i+7:8i],
//     built from the global PS/2 set-2 scan-code defines (SC_*)
//   - das_state_t: per-channel auto-repeat FSM state
`ifndef SC_LEFT
  `define SC_LEFT  8'h6B
`endif
`ifndef SC_RIGHT
  `define SC_RIGHT 8'h74
`endif
`ifndef SC_DOWN
  `define SC_DOWN  8'h72
`endif
`ifndef SC_UP
  `define SC_UP    8'h75
`endif
`ifndef SC_SPACE
  `define SC_SPACE 8'h29
`endif

package input_pkg;
  localparam int CH_LEFT   = 0;
  localparam int CH_RIGHT  = 1;
  localparam int CH_DOWN   = 2;
  localparam int CH_ROTATE = 3;
  localparam int CH_DROP   = 4;

  localparam logic [39:0] KEY_CODES_DEF =
    {`SC_SPACE, `SC_UP, `SC_DOWN, `SC_RIGHT, `SC_LEFT};

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} das_state_t;
endpackage

// File: rtl/das_channel.sv
// das_channel: one command channel.
//   Button synchroniser + optional debounce (INPUT_HUB_DEBOUNCE_EN),
//   held = kb | btn_clean (registered), and the IDLE/DELAY/REPEAT FSM that
//   emits one-shot and auto-repeat cmd pulses counted in game ticks.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   btn        raw asynchronous button
//   kb_nxt     keyboard held state as it will be after this edge
//   tick       game tick pulse
//   held       registered combined held state
//   cmd        one-cycle command pulse
module das_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250_000,
  parameter int DAS_TICKS    = 10,
  parameter int ARR_TICKS    = 2,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic kb_nxt,
  input  logic tick,
  output logic held,
  output logic cmd
);
  localparam int TMAX = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  logic [1:0] sync;
  logic       btn_clean;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], btn};
  end

`ifdef INPUT_HUB_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic [DW-1:0] db_cnt;

  // db_cnt counts consecutive cycles the synchronised input disagrees with
  // btn_clean; agreement at any point (a bounce back) restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt    <= '0;
      btn_clean <= 1'b0;
    end else if (sync[1] == btn_clean) begin
      db_cnt    <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
      db_cnt    <= '0;
      btn_clean <= sync[1];
    end else begin
      db_cnt    <= db_cnt + 1'b1;
    end
  end
`else
  logic unused_dbc;
  assign unused_dbc = (DEBOUNCE_CYC != 0);
  assign btn_clean  = sync[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) held <= 1'b0;
    else     held <= kb_nxt | btn_clean;
  end

  das_state_t    state, state_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt, tcnt_inc;
  logic          das_hit, arr_hit, cmd_nxt;

  assign tcnt_inc = (tcnt == TW'(TMAX)) ? tcnt : tcnt + 1'b1;
  assign das_hit  = tick && (tcnt_inc == TW'(DAS_TICKS));
  assign arr_hit  = tick && (tcnt_inc == TW'(ARR_TICKS));

  // state register; the ~cmd term keeps pulses from ever abutting
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tcnt  <= '0;
      cmd   <= 1'b0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      cmd   <= cmd_nxt & ~cmd;
    end
  end

  // next state; IDLE with held high is by construction a rising edge, and a
  // tick in that cycle is deliberately not counted
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    if (!held) begin
      state_nxt = IDLE;
      tcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = DELAY;
          tcnt_nxt  = '0;
        end
        DELAY: if (REPEAT_EN && tick) begin
          if (das_hit) begin
            state_nxt = REPEAT;
            tcnt_nxt  = '0;
          end else begin
            tcnt_nxt  = tcnt_inc;
          end
        end
        REPEAT: if (tick) tcnt_nxt = arr_hit ? '0 : tcnt_inc;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // output
  always_comb begin
    cmd_nxt = 1'b0;
    if (held) begin
      case (state)
        IDLE:    cmd_nxt = 1'b1;
        DELAY:   cmd_nxt = REPEAT_EN && das_hit;
        REPEAT:  cmd_nxt = arr_hit;
        default: cmd_nxt = 1'b0;
      endcase
    end
  end
endmodule

// File: rtl/input_hub.sv
// input_hub: game-clock input front-end.
//   Game tick generator, keyboard held-state latch from scan-code events and
//   NUM_CH das_channel instances (debounce, OR, DAS/ARR command pulses).
//   Button debounce is enabled by defining INPUT_HUB_DEBOUNCE_EN.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   scan_code    last PS/2 scan code
//   make_break   1 = press, 0 = release
//   scan_valid   qualifies scan_code/make_break
//   btn          raw buttons, active high
//   tick         one-cycle pulse every CLK_HZ/TICK_HZ cycles
//   held         combined held state per channel
//   cmd          one-cycle command pulses per channel
module input_hub
  import input_pkg::*;
#(
  parameter int                  NUM_CH       = 5,
  parameter int                  CLK_HZ       = 25_000_000,
  parameter int                  TICK_HZ      = 60,
  parameter logic [NUM_CH*8-1:0] KEY_CODES    = KEY_CODES_DEF,
  parameter logic [NUM_CH-1:0]   REPEAT_MASK  = 5'b00111,
  parameter int                  DEBOUNCE_CYC = 250_000,
  parameter int                  DAS_TICKS    = 10,
  parameter int                  ARR_TICKS    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        scan_code,
  input  logic              make_break,
  input  logic              scan_valid,
  input  logic [NUM_CH-1:0] btn,
  output logic              tick,
  output logic [NUM_CH-1:0] held,
  output logic [NUM_CH-1:0] cmd
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TDW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TDW-1:0] tick_cnt;
  logic           tick_wrap;

  assign tick_wrap = (tick_cnt == TDW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
      tick     <= tick_wrap;
    end
  end

  logic [NUM_CH-1:0] kb_held, kb_nxt;

  // every channel mapped to the code follows it, so duplicate codes fan out
  always_comb begin
    kb_nxt = kb_held;
    if (scan_valid) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (KEY_CODES[8*i +: 8] == scan_code) kb_nxt[i] = make_break;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) kb_held <= '0;
    else     kb_held <= kb_nxt;
  end

  // channels take kb_nxt so held lands one cycle after the scan event
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    das_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .DAS_TICKS    (DAS_TICKS),
      .ARR_TICKS    (ARR_TICKS),
      .REPEAT_EN    (REPEAT_MASK[i])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .btn    (btn[i]),
      .kb_nxt (kb_nxt[i]),
      .tick   (tick),
      .held   (held[i]),
      .cmd    (cmd[i])
    );
  end
endmodule

// File: tb/tb_input_hub.sv
module tb_input_hub;
  import input_pkg::*;

  localparam int NCH = 5;
  localparam int DIV = 10;
  localparam int DEB = 4;
  localparam int DAS = 3;
  localparam int ARR = 2;
  localparam int HMAX = 4096;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      scan_code = '0;
  logic            make_break = 1'b0;
  logic            scan_valid = 1'b0;
  logic [NCH-1:0]  btn = '0;
  logic            tick;
  logic [NCH-1:0]  held, cmd;

  logic [39:0]     codes_v = KEY_CODES_DEF;
  logic [NCH-1:0]  rmask_v = 5'b00111;

  input_hub #(
    .NUM_CH(NCH), .CLK_HZ(1000), .TICK_HZ(100), .KEY_CODES(KEY_CODES_DEF),
    .REPEAT_MASK(5'b00111), .DEBOUNCE_CYC(DEB), .DAS_TICKS(DAS), .ARR_TICKS(ARR)
  ) dut (
    .clk(clk), .rst(rst), .scan_code(scan_code), .make_break(make_break),
    .scan_valid(scan_valid), .btn(btn), .tick(tick), .held(held), .cmd(cmd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           tick;
    logic [NCH-1:0] held;
    logic [NCH-1:0] cmd;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------- reference model ----------------
  // Arrays indexed by cycle number since the last reset edge.
  logic [NCH-1:0] btn_a   [HMAX];
  logic [NCH-1:0] clean_a [HMAX];
  logic [NCH-1:0] held_a  [HMAX];
  logic [NCH-1:0] kb;
  int             hstart  [NCH];
  int             n;
  exp_t           e;
  logic           stable, v, rising, prev;
  int             k;

  function automatic bit tick_at(int m);
    return (m > 0) && (m % DIV == 0);
  endfunction

  // synchronised button seen in cycle j
  function automatic logic s2_of(int j, int ch);
    if (j < 2) return 1'b0;
    return btn_a[j-2][ch];
  endfunction

  always @(posedge clk) begin
    e = '0;
    if (rst) begin
      n = 0;
      kb = '0;
      clean_a[0] = '0;
      held_a[0] = '0;
    end else begin
      if (n >= HMAX - 2) begin
        $display("FAIL model_depth n=%0d limit=%0d", n, HMAX - 2);
        $fatal(1);
      end
      btn_a[n] = btn;
      if (scan_valid)
        for (int i = 0; i < NCH; i++)
          if (codes_v[8*i +: 8] == scan_code) kb[i] = make_break;
      for (int ch = 0; ch < NCH; ch++) begin
`ifdef INPUT_HUB_DEBOUNCE_EN
        v = ~clean_a[n][ch];
        stable = 1'b1;
        for (int j = n + 1 - DEB; j <= n; j++)
          if (j < 0 || s2_of(j, ch) != v) stable = 1'b0;
        clean_a[n+1][ch] = stable ? v : clean_a[n][ch];
`else
        clean_a[n+1][ch] = s2_of(n + 1, ch);
`endif
        held_a[n+1][ch] = kb[ch] | clean_a[n][ch];
        prev = (n > 0) ? held_a[n-1][ch] : 1'b0;
        rising = held_a[n][ch] && !prev;
        if (rising) hstart[ch] = n;
        k = n / DIV - hstart[ch] / DIV;   // ticks strictly after the press cycle
        e.cmd[ch] = rising ||
                    (held_a[n][ch] && rmask_v[ch] && tick_at(n) &&
                     k >= DAS && ((k - DAS) % ARR == 0));
      end
      e.held = held_a[n+1];
      e.tick = tick_at(n + 1);
      n++;
    end
    expq.push_back(e);
  end

  // ---------------- monitor ----------------
  exp_t me;
  int   mon_cyc = 0;
  int   tick_seen = 0;
  int   cmd_seen [NCH];

  initial for (int i = 0; i < NCH; i++) cmd_seen[i] = 0;

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      me = expq.pop_front();
      checks += 3;
      if (tick !== me.tick) begin
        errors++;
        $display("FAIL tick cyc=%0d got=%b exp=%b", mon_cyc, tick, me.tick);
      end
      if (held !== me.held) begin
        errors++;
        $display("FAIL held cyc=%0d got=%b exp=%b", mon_cyc, held, me.held);
      end
      if (cmd !== me.cmd) begin
        errors++;
        $display("FAIL cmd cyc=%0d got=%b exp=%b", mon_cyc, cmd, me.cmd);
      end
      if (tick === 1'b1) tick_seen++;
      for (int i = 0; i < NCH; i++) if (cmd[i] === 1'b1) cmd_seen[i]++;
    end
    mon_cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int cnt = 1);
    repeat (cnt) @(negedge clk);
    #1;
  endtask

  task automatic scan(logic [7:0] c, logic mk);
    scan_code = c; make_break = mk; scan_valid = 1'b1;
    cyc();
    scan_valid = 1'b0;
  endtask

  task automatic dcheck(string nm, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  int t0, c0, c1, c3;
  logic [7:0] rc;

  initial begin
    // reset, free-running ticks
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    t0 = tick_seen;
    cyc(35);
    dcheck("ticks_in_35", tick_seen - t0, 3);

    // channel 0 make: 2-cycle latency, then DAS/ARR repeats, then break
    c0 = cmd_seen[0];
    scan(codes_v[7:0], 1'b1);
    dcheck("lat_before", cmd_seen[0] - c0, 0);
    cyc(1);
    dcheck("lat_press", cmd_seen[0] - c0, 1);
    cyc($urandom_range(80, 89));
    scan(codes_v[7:0], 1'b0);
    cyc(20);

    // one-shot channel 3
    c3 = cmd_seen[3];
    scan(codes_v[31:24], 1'b1);
    cyc(100);
    scan(codes_v[31:24], 1'b0);
    cyc(10);
    dcheck("oneshot_ch3", cmd_seen[3] - c3, 1);

    // bouncing button 1
    c1 = cmd_seen[1];
    for (int i = 0; i < 5; i++) begin
      btn[1] = 1'b1; cyc(2);
      btn[1] = 1'b0; cyc(2);
    end
    btn[1] = 1'b1; cyc(15);
    btn[1] = 1'b0; cyc(15);
`ifdef INPUT_HUB_DEBOUNCE_EN
    dcheck("bounce_ch1", cmd_seen[1] - c1, 1);
`endif

    // simultaneous presses, then an unmapped code
    c0 = cmd_seen[0];
    c1 = cmd_seen[1];
    btn[1:0] = 2'b11;
    cyc(12);
    dcheck("simul_ch0", cmd_seen[0] - c0, 1);
    dcheck("simul_ch1", cmd_seen[1] - c1, 1);
    scan(8'h1C, 1'b1);
    cyc(3);
    scan(8'h1C, 1'b0);
    btn = '0;
    cyc(15);

    // reset in the middle of auto-repeat
    scan(codes_v[7:0], 1'b1);
    cyc(60);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    c0 = cmd_seen[0];
    cyc(40);
    dcheck("no_cmd_after_rst", cmd_seen[0] - c0, 0);
    scan(codes_v[7:0], 1'b1);
    cyc(3);
    dcheck("fresh_make", cmd_seen[0] - c0, 1);
    scan(codes_v[7:0], 1'b0);
    cyc(10);

    // random soak
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, NCH);
        rc = codes_v[8*(k % NCH) +: 8];
        scan_code  = (k == NCH) ? 8'h1C : rc;
        make_break = 1'($urandom_range(0, 1));
        scan_valid = 1'b1;
      end
      for (int b = 0; b < NCH; b++)
        if ($urandom_range(0, 39) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 249) == 0) rst = 1'b1;
      cyc();
      scan_valid = 1'b0;
      rst = 1'b0;
    end
    btn = '0;
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/input_hub.md
# input_hub

Parametrised input front-end for the game clock domain: generates the 60 Hz game tick, latches keyboard held-state from scan-code events, debounces board buttons, and produces per-channel one-shot and auto-repeat (DAS/ARR) command pulses for game_control. Replaces the ad-hoc tick counter, scan-code decode and button OR-ing at top level with one N-channel block.

## Interface
- NUM_CH, 5: number of command channels.
- CLK_HZ, 25_000_000: clk frequency.
- TICK_HZ, 60: game tick rate; TICK_DIV = CLK_HZ/TICK_HZ (integer division).
- KEY_CODES, {SPACE,UP,DOWN,RIGHT,LEFT codes}: NUM_CH×8 flattened scan codes; channel i uses bits [8i+7:8i].
- REPEAT_MASK, 5'b00111: bit i=1 gives auto-repeat to channel i; 0 gives one-shot only.
- DEBOUNCE_CYC, 250_000: stable cycles before a button change is accepted.
- DAS_TICKS, 10: ticks held before repeat starts.
- ARR_TICKS, 2: ticks between repeats.

Ports:
- clk  in  1  game clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- scan_code  in  8  last PS/2 scan code.
- make_break  in  1  1 = make (press), 0 = break (release).
- scan_valid  in  1  qualifies scan_code/make_break for one cycle; may be tied high.
- btn  in  NUM_CH  raw asynchronous buttons, active high.
- tick  out  1  one-cycle pulse every TICK_DIV cycles.
- held  out  NUM_CH  debounced combined held state.
- cmd  out  NUM_CH  one-cycle command pulses.

## Operation
- Tick: counter 0..TICK_DIV-1, wraps; tick registered high in the cycle after the counter equals TICK_DIV-1.
- Keyboard latch: when scan_valid, every channel whose code equals scan_code loads kb_held[i] <= make_break. Duplicate codes update all matching channels. Non-matching codes are ignored.
- Buttons: 2-flop synchroniser, then debounce (see Configuration) → btn_clean.
- held[i] = kb_held[i] | btn_clean[i], registered.
- Per-channel FSM: IDLE, DELAY, REPEAT.
  - IDLE: on held rising edge → cmd pulse, DELAY, tick count = 0.
  - DELAY, repeat channel: count ticks; at DAS_TICKS → cmd pulse on that tick, REPEAT, count = 0.
  - DELAY, one-shot channel: stays in DELAY until release; never pulses again.
  - REPEAT: cmd pulse every ARR_TICKS ticks.
  - Any state: held low → IDLE immediately, count cleared, no pulse that cycle.
- Channels are independent; simultaneous presses on several channels pulse in the same cycle.
- Rising edge coinciding with tick: only the press pulse is issued, and the tick is not counted.
- Counter widths: $clog2(max+1) of their limits. Counters saturate and never wrap.

## Timing
- Reset values: tick=0, held=0, cmd=0, all FSMs IDLE, all counters 0, kb_held=0.
- First tick occurs TICK_DIV cycles after rst deasserts.
- scan_valid edge → held updated 1 cycle later → cmd 1 cycle after that (2-cycle latency).
- Button: 2 sync cycles + DEBOUNCE_CYC + 1 cycle to held, + 1 cycle to cmd.
- cmd is never high for two consecutive cycles on one channel.
- rst asserted mid-hold clears everything. If the key is still held afterwards, a fresh press event is required; kb_held was cleared, so no pulse occurs until the next make.

## Configuration
- INPUT_HUB_DEBOUNCE_EN defined: per-button counter. A change of the synchronised input is accepted only after it stays stable for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
- INPUT_HUB_DEBOUNCE_EN undefined: btn_clean = synchroniser output; DEBOUNCE_CYC is unused.

## Structure
- Shared package input_pkg holds:
  - channel index constants CH_LEFT=0, CH_RIGHT=1, CH_DOWN=2, CH_ROTATE=3, CH_DROP=4;
  - the default KEY_CODES vector built from the global scan-code defines;
  - the FSM state enum das_state_t.
- One sub-module, das_channel: one channel's debounce, OR, edge detect and DAS FSM, generated NUM_CH times. input_hub holds the tick generator and scan-code match.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (TICK_DIV=10), DEBOUNCE_CYC=4, DAS_TICKS=3, ARR_TICKS=2, debounce enabled.
- Release rst, run 35 cycles → tick pulses at cycles 10, 20, 30 only.
- Make on code KEY_CODES[0] held for 80 cycles → one cmd[0] 2 cycles after scan_valid, next on 3rd tick, then every 2nd tick; break → no further pulses.
- Make on channel 3 (one-shot) held 100 cycles → exactly one cmd[3].
- btn[1] toggles every 2 cycles for 20 cycles, then stays high → held[1] rises only after 4 stable cycles, single cmd[1].
- Press channels 0 and 1 in the same cycle → cmd[0] and cmd[1] pulse together; unknown code 0x1C → no change.
- rst asserted during REPEAT → all outputs 0 next cycle; no cmd after rst release until a new make arrives.
